cdc_pulse_rx_ack: RTL and testbench

Receiving end of a toggle-based pulse-crossing protocol, in the destination clock domain. The sending domain flips a request level once per event. This block:
- synchronizes the request;
- detects each toggle as one event;
- returns an acknowledge toggle level for the sender to synchronize back;
- queues events in a pending counter;
- regenerates them as single-cycle pulses spaced by a programmable minimum gap.

---
 rtl/cdc_pkg.sv | 11 +
 rtl/cdc_sync_bit.sv | 25 ++
 rtl/cdc_pulse_rx_ack.sv | 113 +++++++++++
 tb/tb_cdc_pulse_rx_ack.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// cdc_pkg: shared FSM state type and constants for the toggle pulse-crossing blocks
package cdc_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } cdc_state_t;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int STATS_W = 16;
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: N-stage single-bit synchronizer with asynchronous active-high reset
module cdc_sync_bit
    import cdc_pkg::*;
#(
    parameter int N = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [N-1:0] sync_q;

    if (N < SYNC_STAGES_MIN || N > SYNC_STAGES_MAX) begin : g_bad_n
        $error("cdc_sync_bit: N outside legal synchronizer depth");
    end

    // shift the asynchronous level through the chain; every stage clears on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[N-2:0], d};
    end

    assign q = sync_q[N-1];
endmodule

// File: rtl/cdc_pulse_rx_ack.sv
// cdc_pulse_rx_ack: toggle-request receiver with ack return, pending queue and gap-spaced pulse regeneration
// Optional event statistics enabled by defining CDC_PULSE_RX_ACK_STATS_EN.
module cdc_pulse_rx_ack
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int CNT_W       = 4,
    parameter int MIN_GAP     = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_in,
    input  logic               clr_ovf,
    output logic               ack_out,
    output logic               pulse_out,
    output logic [CNT_W-1:0]   pending,
    output logic               overflow,
    output logic [STATS_W-1:0] evt_total,
    output logic [STATS_W-1:0] evt_dropped
);
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    logic             sync_d;
    logic             evt;
    logic             emit;
    logic             drop;
    logic [CNT_W-1:0] pending_nxt;
    cdc_state_t       state;
    cdc_state_t       state_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_nxt;

    cdc_sync_bit #(.N(SYNC_STAGES)) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (req_in),
        .q   (ack_out)
    );

    // delayed copy of the synchronized level; any difference is one event
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sync_d <= 1'b0;
        else     sync_d <= ack_out;
    end

    assign evt  = ack_out ^ sync_d;
    assign emit = pulse_out;
    assign drop = evt & (&pending) & ~emit;
    assign pending_nxt = (evt & ~drop & ~emit) ? pending + CNT_W'(1) :
                         (~evt & emit)         ? pending - CNT_W'(1) : pending;

    // pending queue and sticky overflow; a drop wins over a same-cycle clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            overflow <= drop | (overflow & ~clr_ovf);
        end
    end

    // emission scheduler: issue a pulse, then hold off MIN_GAP cycles
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        case (state)
            IDLE:  if (pending != '0) state_nxt = PULSE;
            PULSE: begin
                if (MIN_GAP == 0) begin
                    state_nxt = (pending_nxt != '0) ? PULSE : IDLE;
                end else begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_W'(MIN_GAP - 1);
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = (pending != '0) ? PULSE : IDLE;
                else               gap_nxt   = gap_cnt - GAP_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state, gap counter and a glitch-free registered pulse mirroring PULSE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            pulse_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_nxt;
            pulse_out <= (state_nxt == PULSE);
        end
    end

`ifdef CDC_PULSE_RX_ACK_STATS_EN
    // total events wrap; dropped events saturate; only reset clears them
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            evt_total   <= '0;
            evt_dropped <= '0;
        end else begin
            evt_total <= evt_total + STATS_W'(evt);
            if (drop && !(&evt_dropped)) evt_dropped <= evt_dropped + STATS_W'(1);
        end
    end
`else
    assign evt_total   = '0;
    assign evt_dropped = '0;
`endif
endmodule

// File: tb/tb_cdc_pulse_rx_ack.sv
// tb_cdc_pulse_rx_ack: randomized self-checking bench for two configurations (MIN_GAP 0 / CNT_W 4 and MIN_GAP 2 / CNT_W 2)
module tb_cdc_pulse_rx_ack;
    localparam int S = 3;
`ifdef CDC_PULSE_RX_ACK_STATS_EN
    localparam logic [31:0] STATS_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] STATS_MASK = 32'h0;
`endif
    int mg [2] = '{0, 2};
    int cw [2] = '{4, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_in = 1'b0;
    logic clr_ovf = 1'b0;
    logic [1:0] ack_o, pulse_o, ovf_o;
    logic [3:0] pend0;
    logic [1:0] pend1;
    logic [15:0] tot0, tot1, drp0, drp1;

    int vectors = 0;
    int miscompares = 0;

    bit hist[$];
    int m_cyc;
    int m_pend [2];
    int m_last [2];
    int m_tot [2];
    int m_drp [2];
    bit m_pulse [2];
    bit m_ovf [2];

    always #5 clk = ~clk;

    cdc_pulse_rx_ack #(.SYNC_STAGES(S), .CNT_W(4), .MIN_GAP(0)) d0 (
        .CLK(clk), .RST(rst), .req_in(req_in), .clr_ovf(clr_ovf),
        .ack_out(ack_o[0]), .pulse_out(pulse_o[0]), .pending(pend0), .overflow(ovf_o[0]),
        .evt_total(tot0), .evt_dropped(drp0)
    );

    cdc_pulse_rx_ack #(.SYNC_STAGES(S), .CNT_W(2), .MIN_GAP(2)) d1 (
        .CLK(clk), .RST(rst), .req_in(req_in), .clr_ovf(clr_ovf),
        .ack_out(ack_o[1]), .pulse_out(pulse_o[1]), .pending(pend1), .overflow(ovf_o[1]),
        .evt_total(tot1), .evt_dropped(drp1)
    );

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    function automatic logic [38:0] obs(int i);
        return (i == 0) ? {ack_o[0], pulse_o[0], ovf_o[0], pend0, tot0, drp0}
                        : {ack_o[1], pulse_o[1], ovf_o[1], 2'b00, pend1, tot1, drp1};
    endfunction

    function automatic logic [38:0] mexp(int i);
        logic [31:0] st;
        st = {16'(m_tot[i]), 16'(m_drp[i])} & STATS_MASK;
        return {hist[S-1], m_pulse[i], m_ovf[i], 4'(m_pend[i]), st};
    endfunction

    task automatic model_reset();
        hist = {};
        for (int j = 0; j <= S; j++) hist.push_back(1'b0);
        m_cyc = 0;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_last[i] = -100; m_tot[i] = 0; m_drp[i] = 0;
            m_pulse[i] = 1'b0; m_ovf[i] = 1'b0;
        end
    endtask

    // behavioural view: events are level changes of the request seen S-1 edges late;
    // pulses respect a minimum spacing, back-to-back only when MIN_GAP is 0
    task automatic model_step();
        bit ev, emit, drop;
        int cap, nw;
        m_cyc++;
        ev = hist[S-1] ^ hist[S];
        hist.push_front(req_in);
        void'(hist.pop_back());
        for (int i = 0; i < 2; i++) begin
            cap  = (1 << cw[i]) - 1;
            emit = m_pulse[i];
            drop = ev && m_pend[i] == cap && !emit;
            nw   = m_pend[i] + ((ev && !drop) ? 1 : 0) - (emit ? 1 : 0);
            m_ovf[i] = drop ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf[i]);
            m_pulse[i] = emit ? (mg[i] == 0 && nw != 0) : (m_cyc - m_last[i] > mg[i] && m_pend[i] != 0);
            if (m_pulse[i]) m_last[i] = m_cyc;
            m_pend[i] = nw;
            m_tot[i] = (m_tot[i] + (ev ? 1 : 0)) % 65536;
            if (drop && m_drp[i] < 65535) m_drp[i]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic idle(int n);
        clr_ovf = 1'b1;
        repeat (n) begin
            tick();
            @(negedge clk);
        end
        clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs(i) !== 39'h0) begin
                miscompares++;
                $display("FAIL reset inst%0d: got %h want 0", i, obs(i));
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_event();
        logic [6:0] ex;
        for (int e = 1; e <= 16; e++) begin
            if (e == 10) req_in = 1'b1;
            tick();
            ex = {e >= 12, e == 14, 1'b0, (e == 13 || e == 14) ? 4'd1 : 4'd0};
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i)[38:32] !== ex) begin
                    miscompares++;
                    $display("FAIL single inst%0d edge%0d: got %b want %b", i, e, obs(i)[38:32], ex);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_burst();
        int np [2];
        int sent = 0, low = 0, gap_min = 99;
        bit seen = 1'b0;
        np = '{0, 0};
        idle(30);
        for (int c = 0; c < 120; c++) begin
            if (sent < 4 && ack_o[1] === req_in) begin
                req_in = ~req_in;
                sent++;
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== mexp(i)) begin
                    miscompares++;
                    $display("FAIL burst inst%0d @%0t: got %h want %h", i, $time, obs(i), mexp(i));
                end
                if (pulse_o[i]) np[i]++;
            end
            if (pulse_o[1]) begin
                if (seen && low < gap_min) gap_min = low;
                seen = 1'b1;
                low = 0;
            end else low++;
            @(negedge clk);
        end
        vectors++;
        if (sent != 4 || np[0] != 4 || np[1] != 4 || gap_min < 2 || pend0 !== 4'd0 || pend1 !== 2'd0) begin
            miscompares++;
            $display("FAIL burst_summary: got sent=%0d pulses=%0d/%0d gap=%0d pend=%0d/%0d want 4 4/4 >=2 0/0",
                     sent, np[0], np[1], gap_min, pend0, pend1);
        end
    endtask

    task automatic test_saturation();
        int maxp = 0;
        idle(30);
        for (int c = 0; c < 60; c++) begin
            if (c < 8 || (c >= 40 && c < 50)) req_in = ~req_in;
            clr_ovf = (c == 20) || (c >= 40);
            tick();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== mexp(i)) begin
                    miscompares++;
                    $display("FAIL saturation inst%0d @%0t: got %h want %h", i, $time, obs(i), mexp(i));
                end
            end
            if (int'(pend1) > maxp) maxp = int'(pend1);
            if (c == 12 || c == 20) begin
                vectors++;
                if (ovf_o[1] !== (c == 12)) begin
                    miscompares++;
                    $display("FAIL sat_ovf c%0d: got %b want %b", c, ovf_o[1], c == 12);
                end
            end
            @(negedge clk);
        end
        clr_ovf = 1'b0;
        vectors++;
        if (maxp != 3) begin
            miscompares++;
            $display("FAIL sat_cap: got %0d want 3", maxp);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ex;
        idle(30);
        for (int c = 0; c < 14; c++) begin
            if (c == 0 || c == 2 || c == 3 || c == 4) req_in = ~req_in;
            tick();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== mexp(i)) begin
                    miscompares++;
                    $display("FAIL b2b inst%0d @%0t: got %h want %h", i, $time, obs(i), mexp(i));
                end
            end
            if (c >= 4 && c <= 8) begin
                ex = (c <= 7) ? 5'b1_0001 : 5'b0_0000;
                vectors++;
                if ({pulse_o[0], pend0} !== ex) begin
                    miscompares++;
                    $display("FAIL b2b_pulse c%0d: got %b want %b", c, {pulse_o[0], pend0}, ex);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        idle(30);
        for (int c = 0; c <= 5; c++) begin
            if (c < 4) req_in = ~req_in;
            tick();
            if (c < 5) @(negedge clk);
        end
        vectors++;
        if ({pulse_o[1], pend1} !== 3'b0_10) begin
            miscompares++;
            $display("FAIL mid_pre: got %b want 010", {pulse_o[1], pend1});
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs(i) !== 39'h0) begin
                miscompares++;
                $display("FAIL mid_async inst%0d: got %h want 0", i, obs(i));
            end
        end
        @(negedge clk);
        req_in = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== mexp(i) || pulse_o[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mid_after inst%0d @%0t: got %h want %h", i, $time, obs(i), mexp(i));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (rst) model_reset();
            if ($urandom_range(0, 2) == 0) req_in = ~req_in;
            clr_ovf = ($urandom_range(0, 7) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs(i) !== mexp(i)) begin
                    miscompares++;
                    $display("FAIL random inst%0d @%0t: got %h want %h", i, $time, obs(i), mexp(i));
                end
            end
            @(negedge clk);
        end
        rst = 1'b0;
        clr_ovf = 1'b0;
    endtask

`ifdef CDC_PULSE_RX_ACK_STATS_EN
    task automatic test_stats_wrap();
        rst = 1'b1;
        model_reset();
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 65537; c++) begin
            req_in = ~req_in;
            tick();
            @(negedge clk);
        end
        repeat (40) begin
            tick();
            @(negedge clk);
        end
        vectors++;
        if ({tot0, drp0} !== {16'd1, 16'd0} || obs(0) !== mexp(0)) begin
            miscompares++;
            $display("FAIL stats_wrap: got total=%0d dropped=%0d want 1 0", tot0, drp0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_event();
        test_burst();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef CDC_PULSE_RX_ACK_STATS_EN
        test_stats_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
